// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that shares the two CDB writeback ports
// among NUM_FU result sources. Grants are combinational; the CDB broadcast is
// registered, so a packet granted in cycle N is visible in cycle N+1.
// Packets are carried as flattened per-FU fields (valid, dest_tag, result,
// exception); FU i occupies bit slice [i*W +: W] of each field vector.
module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int PIPE_WIDTH = 2,
  parameter int CNT_BITS   = 16,
  parameter int TAG_BITS   = 6,
  parameter int DATA_BITS  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_flush,
  input  logic [NUM_FU-1:0]                i_fu_valid,
  input  logic [NUM_FU*TAG_BITS-1:0]       i_fu_dest_tag,
  input  logic [NUM_FU*DATA_BITS-1:0]      i_fu_result,
  input  logic [NUM_FU-1:0]                i_fu_exception,
  output logic [NUM_FU-1:0]                o_fu_gnt,
  output logic [PIPE_WIDTH-1:0]            o_cdb_valid,
  output logic [PIPE_WIDTH*TAG_BITS-1:0]   o_cdb_dest_tag,
  output logic [PIPE_WIDTH*DATA_BITS-1:0]  o_cdb_result,
  output logic [PIPE_WIDTH-1:0]            o_cdb_exception,
  output logic [CNT_BITS-1:0]              o_stall_cnt
);

  localparam int PTR_BITS = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [PTR_BITS:0]   NUM_FU_W = NUM_FU[PTR_BITS:0];
  localparam logic [PTR_BITS-1:0] LAST_IDX = PTR_BITS'(NUM_FU - 1);

  logic [PTR_BITS-1:0]          r_ptr;
  logic [PTR_BITS-1:0]          w_ptr_nxt;
  logic [PTR_BITS:0]            w_scan;
  logic [PTR_BITS-1:0]          w_idx0;
  logic [PTR_BITS-1:0]          w_idx1;
  logic [PTR_BITS-1:0]          w_last;
  logic                         w_found0;
  logic                         w_found1;
  logic                         w_extra;
  logic                         w_grant_en;
  logic                         w_slot0;
  logic                         w_slot1;
  logic                         w_stall;
  logic [NUM_FU-1:0]            w_gnt;
  logic [PIPE_WIDTH-1:0]        r_cdb_valid;
  logic [PIPE_WIDTH*TAG_BITS-1:0]  r_cdb_dest_tag;
  logic [PIPE_WIDTH*DATA_BITS-1:0] r_cdb_result;
  logic [PIPE_WIDTH-1:0]        r_cdb_exception;
  logic [CNT_BITS-1:0]          r_stall_cnt;

  // Circular scan from r_ptr: first two requesters take slots 0/1; a third
  // requester means somebody lost arbitration this cycle.
  always_comb begin
    w_found0 = 1'b0;
    w_found1 = 1'b0;
    w_extra  = 1'b0;
    w_idx0   = '0;
    w_idx1   = '0;
    w_scan   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_scan = {1'b0, r_ptr} + (PTR_BITS + 1)'(k);
      if (w_scan >= NUM_FU_W) w_scan = w_scan - NUM_FU_W;
      if (i_fu_valid[w_scan[PTR_BITS-1:0]]) begin
        if (!w_found0) begin
          w_found0 = 1'b1;
          w_idx0   = w_scan[PTR_BITS-1:0];
        end else if (!w_found1) begin
          w_found1 = 1'b1;
          w_idx1   = w_scan[PTR_BITS-1:0];
        end else begin
          w_extra = 1'b1;
        end
      end
    end
  end

  // Grant vector and next pointer; reset and flush both suppress every grant.
  always_comb begin
    w_grant_en = rst & ~i_flush;
    w_slot0    = w_found0 & w_grant_en;
    w_slot1    = w_found1 & w_grant_en;
    w_gnt      = '0;
    if (w_slot0) w_gnt[w_idx0] = 1'b1;
    if (w_slot1) w_gnt[w_idx1] = 1'b1;
    w_last    = w_found1 ? w_idx1 : w_idx0;
    w_ptr_nxt = r_ptr;
    if (i_flush) begin
      w_ptr_nxt = '0;
    end else if (w_found0) begin
      w_ptr_nxt = (w_last == LAST_IDX) ? '0 : w_last + 1'b1;
    end
    // grants are min(2, requests), so a loser exists exactly when a third requester does
    w_stall = ~i_flush & w_extra;
  end

  // Priority pointer, registered CDB broadcast and saturating contention counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr           <= '0;
      r_cdb_valid     <= '0;
      r_cdb_dest_tag  <= '0;
      r_cdb_result    <= '0;
      r_cdb_exception <= '0;
      r_stall_cnt     <= '0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_cdb_valid <= {w_slot1, w_slot0};
      r_cdb_dest_tag[0 +: TAG_BITS]         <= w_slot0 ? i_fu_dest_tag[w_idx0*TAG_BITS +: TAG_BITS] : '0;
      r_cdb_dest_tag[TAG_BITS +: TAG_BITS]  <= w_slot1 ? i_fu_dest_tag[w_idx1*TAG_BITS +: TAG_BITS] : '0;
      r_cdb_result[0 +: DATA_BITS]          <= w_slot0 ? i_fu_result[w_idx0*DATA_BITS +: DATA_BITS] : '0;
      r_cdb_result[DATA_BITS +: DATA_BITS]  <= w_slot1 ? i_fu_result[w_idx1*DATA_BITS +: DATA_BITS] : '0;
      r_cdb_exception <= {w_slot1 & i_fu_exception[w_idx1], w_slot0 & i_fu_exception[w_idx0]};
      if (w_stall && (r_stall_cnt != {CNT_BITS{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign o_fu_gnt        = w_gnt;
  assign o_cdb_valid     = r_cdb_valid;
  assign o_cdb_dest_tag  = r_cdb_dest_tag;
  assign o_cdb_result    = r_cdb_result;
  assign o_cdb_exception = r_cdb_exception;
  assign o_stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with NUM_FU = 4. Inputs change 1 ns after a
// rising edge; grants are sampled on the falling edge and registered outputs
// 1 ns after the rising edge.
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [3:0]   fu_valid;
  logic [23:0]  fu_tag;
  logic [127:0] fu_result;
  logic [3:0]   fu_exc;
  logic [3:0]   fu_gnt;
  logic [1:0]   cdb_valid;
  logic [11:0]  cdb_tag;
  logic [63:0]  cdb_result;
  logic [1:0]   cdb_exc;
  logic [15:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

  cdb_arbiter #(
    .NUM_FU(4), .PIPE_WIDTH(2), .CNT_BITS(16), .TAG_BITS(6), .DATA_BITS(32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_flush        (flush),
    .i_fu_valid     (fu_valid),
    .i_fu_dest_tag  (fu_tag),
    .i_fu_result    (fu_result),
    .i_fu_exception (fu_exc),
    .o_fu_gnt       (fu_gnt),
    .o_cdb_valid    (cdb_valid),
    .o_cdb_dest_tag (cdb_tag),
    .o_cdb_result   (cdb_result),
    .o_cdb_exception(cdb_exc),
    .o_stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic set_fu(input int i, input logic v, input logic [5:0] t,
                        input logic [31:0] r, input logic e);
    fu_valid[i]          = v;
    fu_tag[i*6 +: 6]     = t;
    fu_result[i*32 +: 32] = r;
    fu_exc[i]            = e;
  endtask

  task automatic clear_fu();
    fu_valid  = '0;
    fu_tag    = '0;
    fu_result = '0;
    fu_exc    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_gnt [4];
    exp_gnt[0] = 4'b0011;
    exp_gnt[1] = 4'b1100;
    exp_gnt[2] = 4'b0011;
    exp_gnt[3] = 4'b1100;

    // reset with all FUs requesting
    rst   = 1'b0;
    flush = 1'b0;
    clear_fu();
    for (int i = 0; i < 4; i++) set_fu(i, 1'b1, 6'(10 + i), 32'h200 + 32'(i), 1'b0);
    #2;
    chk("rst_gnt", 64'(fu_gnt), 64'h0);
    chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("rst_stall", 64'(stall_cnt), 64'h0);
    @(posedge clk);
    tick();
    chk("rst_hold_gnt", 64'(fu_gnt), 64'h0);
    chk("rst_hold_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("rst_hold_stall", 64'(stall_cnt), 64'h0);

    // single requester after release: FU1, slot 0 only
    rst = 1'b1;
    clear_fu();
    set_fu(1, 1'b1, 6'd5, 32'hAAAAAAAA, 1'b0);
    @(negedge clk);
    chk("single_gnt", 64'(fu_gnt), 64'b0010);
    tick();
    chk("single_cdb_valid", 64'(cdb_valid), 64'b01);
    chk("single_tag0", 64'(cdb_tag[5:0]), 64'd5);
    chk("single_res0", 64'(cdb_result[31:0]), 64'hAAAAAAAA);

    // flush with nothing requesting brings ptr back to 0
    clear_fu();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush0_cdb_valid", 64'(cdb_valid), 64'h0);

    // dual grant from ptr 0
    set_fu(0, 1'b1, 6'd0, 32'h100, 1'b0);
    set_fu(2, 1'b1, 6'd2, 32'h102, 1'b0);
    @(negedge clk);
    chk("dual_gnt", 64'(fu_gnt), 64'b0101);
    tick();
    chk("dual_cdb_valid", 64'(cdb_valid), 64'b11);
    chk("dual_tag0", 64'(cdb_tag[5:0]), 64'd0);
    chk("dual_tag1", 64'(cdb_tag[11:6]), 64'd2);
    chk("dual_res1", 64'(cdb_result[63:32]), 64'h102);

    // ptr is now 3: FU3 takes slot 0, FU0 wraps into slot 1
    clear_fu();
    set_fu(0, 1'b1, 6'd7, 32'h107, 1'b0);
    set_fu(3, 1'b1, 6'd9, 32'h109, 1'b0);
    @(negedge clk);
    chk("wrap_gnt", 64'(fu_gnt), 64'b1001);
    tick();
    chk("wrap_tag0", 64'(cdb_tag[5:0]), 64'd9);
    chk("wrap_tag1", 64'(cdb_tag[11:6]), 64'd7);

    // fairness: all four requesting continuously from ptr 0
    clear_fu();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) set_fu(i, 1'b1, 6'(10 + i), 32'h200 + 32'(i), 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("fair_gnt", 64'(fu_gnt), 64'(exp_gnt[c]));
      tick();
      chk("fair_tag0", 64'(cdb_tag[5:0]), 64'(10 + 2 * (c % 2)));
      chk("fair_tag1", 64'(cdb_tag[11:6]), 64'(11 + 2 * (c % 2)));
      chk("fair_stall", 64'(stall_cnt), 64'(c + 1));
    end

    // backpressure: FU2 loses, holds its packet, wins next cycle
    clear_fu();
    set_fu(0, 1'b1, 6'd30, 32'h300, 1'b0);
    set_fu(1, 1'b1, 6'd31, 32'h301, 1'b0);
    set_fu(2, 1'b1, 6'd32, 32'h302, 1'b1);
    @(negedge clk);
    chk("bp_gnt_a", 64'(fu_gnt), 64'b0011);
    tick();
    chk("bp_tag0_a", 64'(cdb_tag[5:0]), 64'd30);
    chk("bp_tag1_a", 64'(cdb_tag[11:6]), 64'd31);
    chk("bp_exc_a", 64'(cdb_exc), 64'b00);
    chk("bp_stall_a", 64'(stall_cnt), 64'd5);
    set_fu(0, 1'b1, 6'd33, 32'h303, 1'b0);
    set_fu(1, 1'b0, 6'd0, 32'h0, 1'b0);
    @(negedge clk);
    chk("bp_gnt_b", 64'(fu_gnt), 64'b0101);
    tick();
    chk("bp_tag0_b", 64'(cdb_tag[5:0]), 64'd32);
    chk("bp_res0_b", 64'(cdb_result[31:0]), 64'h302);
    chk("bp_exc_b", 64'(cdb_exc), 64'b01);
    chk("bp_tag1_b", 64'(cdb_tag[11:6]), 64'd33);
    chk("bp_stall_b", 64'(stall_cnt), 64'd5);

    // flush with contended requests (ptr is 1 beforehand)
    clear_fu();
    set_fu(0, 1'b1, 6'd40, 32'h400, 1'b0);
    set_fu(1, 1'b1, 6'd41, 32'h401, 1'b0);
    set_fu(2, 1'b1, 6'd42, 32'h402, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_gnt", 64'(fu_gnt), 64'h0);
    tick();
    flush = 1'b0;
    chk("flush_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("flush_stall", 64'(stall_cnt), 64'd5);
    set_fu(2, 1'b0, 6'd0, 32'h0, 1'b0);
    @(negedge clk);
    chk("postflush_gnt", 64'(fu_gnt), 64'b0011);
    tick();
    chk("postflush_tag0", 64'(cdb_tag[5:0]), 64'd40);
    chk("postflush_tag1", 64'(cdb_tag[11:6]), 64'd41);

    // reset mid-operation discards the in-flight broadcast at once
    clear_fu();
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("midrst_stall", 64'(stall_cnt), 64'h0);
    for (int i = 0; i < 4; i++) set_fu(i, 1'b1, 6'(50 + i), 32'h500 + 32'(i), 1'b0);
    #1;
    chk("midrst_gnt", 64'(fu_gnt), 64'h0);
    tick();
    chk("midrst_hold_valid", 64'(cdb_valid), 64'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("postrst_gnt", 64'(fu_gnt), 64'b0011);

    // saturation of the contention counter
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe", 64'(stall_cnt), 64'hFFFE);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_ffff", 64'(stall_cnt), 64'hFFFF);
    @(negedge clk);
    chk("sat_gnt", 64'(fu_gnt), 64'b0011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the two common data bus (CDB) writeback ports among `NUM_FU` functional-unit result sources. It sits between the execute stage and every CDB consumer (ROB writeback, reservation-station wakeup). Each cycle it grants up to `PIPE_WIDTH` pending results, drives them onto registered `cdb_ports` one cycle later, and backpressures losers. Wrong-path results are dropped on `flush`.

## Interface
Parameters:
- `NUM_FU`, 4: number of result sources, from 2 to 8.
- `PIPE_WIDTH`, 2 (uarch_pkg): number of CDB ports. The block is defined only for 2.
- `CNT_BITS`, 16: width of the contention counter.

Ports:
- `clk`  in  1  the single clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous active-low reset (reset while 0).
- `flush`  in  1  ROB misprediction/exception flush.
- `fu_pkts`  in  `writeback_packet_t [NUM_FU]`  result offers. `is_valid` is the request.
- `fu_gnt`  out  `NUM_FU`  combinational grant. The FU's packet is consumed this cycle.
- `cdb_ports`  out  `writeback_packet_t [PIPE_WIDTH]`  registered CDB broadcast.
- `stall_cnt`  out  `CNT_BITS`  saturating count of cycles in which any valid request was not granted.

## Operation
Request and grant handshake:
- A request is `fu_pkts[i].is_valid == 1`.
- The FU holds the packet stable until it sees `fu_gnt[i] == 1` at a rising edge.
- A packet is transferred when `is_valid && fu_gnt[i]` are both 1 at the edge.

Grant selection:
- State is a priority pointer `ptr` of width `$clog2(NUM_FU)`.
- Scan requesters circularly starting at `ptr`.
  - The first valid requester found → slot 0.
  - The second valid requester found → slot 1.
- Total grants per cycle ≤ 2. `fu_gnt` is one-hot per slot and never grants the same FU twice.

Pointer update:
- If ≥1 grant: `ptr ← (index of last granted FU + 1) mod NUM_FU`.
- If no grant: `ptr` is unchanged.
- Fairness: a continuously requesting FU is granted no later than its ceil(NUM_FU/2)-th requesting cycle.

CDB output registers:
- `cdb_ports[0] ←` the slot-0 packet if slot 0 is granted, else `'0`.
- `cdb_ports[1] ←` the slot-1 packet if slot 1 is granted, else `'0`.
- Packets pass through unmodified: `dest_tag`, `result`, `exception`.
- Slot 1 is never valid while slot 0 is invalid.

Flush, in the cycle `flush == 1`:
- `fu_gnt = '0`.
- Next-cycle `cdb_ports` are all `'0`.
- `ptr ← 0`.
- `stall_cnt` does not count that cycle.
- FUs are flushed by the same signal; the arbiter does not track their contents.

Contention counter:
- Increments in a non-flush cycle when (number of valid requests) > (number of grants).
- Saturates at all-ones.
- Reset only by `rst`.

Boundary cases:
- All `NUM_FU` requesting: exactly 2 grants.
- Scan wrap-around from `NUM_FU-1` to 0 is seamless.
- One requester: slot 0 only.

## Timing
- Grant latency: 0 cycles (combinational from `fu_pkts`, `ptr`, `flush`).
- CDB latency: 1 cycle. A packet granted in cycle N appears on `cdb_ports` in cycle N+1, for exactly one cycle.
- Throughput: 2 results per cycle sustained.
- Reset values, asynchronous on `rst` going low:
  - `cdb_ports = '0` (both `is_valid = 0`).
  - `ptr = 0`.
  - `stall_cnt = 0`.
  - `fu_gnt = 0` while `rst == 0`.
- Reset mid-operation: in-flight `cdb_ports` contents are discarded immediately. No grant is issued until the first edge after `rst` returns high.
- Flush and requests in the same cycle: flush wins, no transfer occurs.

## Test plan
1. **Reset.** Drive `rst = 0` with all FUs valid → `fu_gnt = 0`, `cdb_ports[*].is_valid = 0`, `stall_cnt = 0`. Release reset, FU1 valid with tag 5 / 0xAAAAAAAA → `fu_gnt = 4'b0010`; next cycle `cdb_ports[0]` = tag 5 / 0xAAAAAAAA, `cdb_ports[1].is_valid = 0`.
2. **Dual grant.** FU0 (tag 0) and FU2 (tag 2) valid, `ptr = 0` → `fu_gnt = 4'b0101`; next cycle `cdb_ports[0]` = tag 0, `cdb_ports[1]` = tag 2; `ptr = 3`.
3. **Fairness and wrap-around.** All 4 FUs hold requests continuously from `ptr = 0`:
   - Grants are `0011`, `1100`, `0011`, …
   - FU3 is granted on its 2nd cycle.
   - `stall_cnt` increments once per contended cycle.
4. **Backpressure.** 3 FUs valid → the ungranted FU holds its packet; it is granted the next cycle with identical payload on the CDB; no packet is duplicated or lost (scoreboard of tags).
5. **Flush.** `flush = 1` with FU0 and FU1 valid → `fu_gnt = 0`; next-cycle `cdb_ports` invalid; `ptr = 0`; `stall_cnt` unchanged.
6. **Saturation.** Force 65,540 contended cycles → `stall_cnt` holds at `16'hFFFF`.
